qspi_flash_responder: RTL and testbench
=======================================

Name: qspi_flash_responder

Overview:
- Fabric-side QSPI flash target that answers the hard MCU's QSPI master (SPI mode 0, MSB first) from an on-chip synchronous-read byte memory.
- Lets the flash demo run XIP/boot reads against FPGA RAM instead of external flash.
- Oversamples qspi_sclk/qspi_ss/qspi_txd on the fabric clock.
- Decodes READ 0x03, FAST READ 0x0B, QUAD OUTPUT READ 0x6B and READ ID 0x9F, then drives the MCU's qspi_rxd lines.

Parameters:
- ADDR_W, 24, width of the flash byte address; memory index is addr[ADDR_W-1:0].
- JEDEC_ID, 24'hEF4018, 3 bytes returned by 0x9F, MSB byte first.
- DUMMY_CLKS, 8, dummy sclk cycles for 0x0B/0x6B.
- SYNC_STAGES, 2, synchronizer depth on sclk/ss/txd.

Ports:
- clk  in  1  fabric clock; must be >= 8x qspi_sclk frequency.
- rstn  in  1  synchronous, active-low reset.
- qspi_sclk  in  1  serial clock from MCU.
- qspi_ss  in  1  chip select from MCU, active low.
- qspi_txd  in  4  MCU output lines; only bit0 (IO0/MOSI) is used.
- rsp_dout  out  4  value for the MCU qspi_rxd lines.
- rsp_oe  out  4  per-line drive enable, active high.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rd_data  in  8  read data, valid exactly 1 clk after mem_rd_en.
- busy  out  1  high while ss is low (synchronized).
- cmd_err  out  1  one-clk pulse on unsupported opcode.

Behaviour:
- Reset: all outputs 0. State IDLE. Shift register, counters and prefetch buffer cleared.
- Synchronization: sclk, ss and txd[0] each pass through SYNC_STAGES flops.
  - rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d.
  - All protocol actions key off these one-clk pulses.
- Sampling rule: input bits are sampled on rise; output bits are updated on fall.
- ss deasserted (sync'd high) in any state: next clk goes to IDLE, rsp_oe=0, rsp_dout=0, counters cleared. This takes priority over a coincident rise/fall.
- Reset asserted mid-transfer behaves the same as ss deassertion and also clears pending memory data.
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, IDOUT, IGNORE.
  - IDLE: ss low -> CMD, bit counter = 0.
  - CMD: shift 8 bits on rise. After the 8th:
    - 0x03, 0x0B, 0x6B -> ADDR.
    - 0x9F -> IDOUT.
    - Other opcodes -> IGNORE and pulse cmd_err.
  - ADDR: shift 24 bits, MSB first. After the 24th bit, latch the address (truncated to ADDR_W) and issue mem_rd_en with mem_addr = addr.
    - 0x03 -> DATA.
    - 0x0B/0x6B -> DUMMY.
  - DUMMY: count DUMMY_CLKS rises, then go to DATA. Line 1 is not driven.
  - DATA, single (0x03/0x0B):
    - rsp_oe = 4'b0010.
    - One bit per fall on rsp_dout[1]. Other rsp_dout bits are 0.
  - DATA, quad (0x6B):
    - rsp_oe = 4'b1111.
    - Per fall, rsp_dout = nibble: [7:4] first, then [3:0].
  - IDOUT: rsp_oe = 4'b0010. Shift JEDEC_ID out on rsp_dout[1], 24 bits, one bit per fall. After the 24th bit, keep driving 0.
  - IGNORE: outputs undriven until ss deasserts.
- Byte pipeline:
  - A one-byte prefetch buffer (valid flag) captures mem_rd_data 1 clk after mem_rd_en.
  - When the current byte's first bit is loaded on fall, the prefetch byte moves into the shift register.
  - On that same clk, address increments and the next mem_rd_en is issued, so there is at most 1 outstanding read.
- Address wrap: increment modulo 2^ADDR_W (0xFFFFFF -> 0x000000 for ADDR_W=24).
- Underrun: if a byte is needed and the prefetch buffer is not valid, shift 0xFF. This cannot occur when the clk ratio is >= 8; the bench asserts it never happens.
- First data bit (0x03): the 24th address rise triggers the read. Data is returned before the following fall at ratio >= 8, so the first bit appears on that fall.
- Transfer length is unbounded; the block streams until ss deasserts.

Decomposition:
- Package qspi_rsp_pkg holds:
  - Opcode constants OP_READ=8'h03, OP_FAST=8'h0B, OP_QOR=8'h6B, OP_RDID=8'h9F.
  - The FSM state enum.
  - The width of the DUMMY counter.
- One sub-module, qspi_rsp_sync: the SYNC_STAGES synchronizer plus rise/fall edge detect for sclk, and level sync for ss/txd0.

Test Plan:
- 0x9F, 24 clks, sclk = clk/8 -> rsp_dout[1] serializes EF4018. rsp_oe = 4'b0010 during the ID bits. cmd_err stays 0.
- 0x03, addr 0x000010, mem[0x10..0x13] = A5,3C,FF,00, 32 data clks -> bytes A5 3C FF 00 on IO1. mem_addr sequence 0x10,0x11,0x12,0x13,0x14.
- 0x6B, addr 0x000100, 8 dummy, 4 data clks, mem = 12,34 -> nibbles 1,2,3,4. rsp_oe = 4'b1111 only in DATA and 0 during DUMMY.
- 0x0B, addr 0xFFFFFF, 16 data clks -> mem_addr 0xFFFFFF then 0x000000. Data is mem[FFFFFF] followed by mem[0].
- Opcode 0x05 -> cmd_err pulses 1 clk, rsp_oe stays 0 for the whole frame. A following 0x9F frame responds correctly.
- ss raised mid-byte in a 0x03 read (after 5 data bits) -> rsp_oe = 0 within SYNC_STAGES+1 clks, FSM returns to IDLE. The next 0x03 frame starts clean.
- Reset asserted mid-0x6B read -> the same recovery behaviour.

Source files
------------

// File: rtl/qspi_rsp_pkg.sv
// qspi_rsp_pkg: opcodes, sequencer states and counter widths
// shared by the QSPI flash responder and its helpers.
package qspi_rsp_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_FAST = 8'h0B;
    localparam logic [7:0] OP_QOR  = 8'h6B;
    localparam logic [7:0] OP_RDID = 8'h9F;

    // Wide enough for up to 15 dummy clocks.
    localparam int DUMMY_CW = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IDOUT,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/qspi_rsp_sync.sv
// qspi_rsp_sync: brings sclk/ss/io0 into the fabric clock
// domain and turns sclk into one-clk rise/fall pulses.
module qspi_rsp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic sclk,
    input  logic ss,
    input  logic txd0,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_s,
    output logic txd0_s
);

    logic [STAGES-1:0] sclk_q, sclk_d;
    logic [STAGES-1:0] ss_q, ss_d;
    logic [STAGES-1:0] txd_q, txd_d;
    logic              sclk_dly_q, sclk_dly_d;

    // Shift each line one stage deeper every clk
    always_comb begin
        sclk_d     = {sclk_q[STAGES-2:0], sclk};
        ss_d       = {ss_q[STAGES-2:0], ss};
        txd_d      = {txd_q[STAGES-2:0], txd0};
        sclk_dly_d = sclk_q[STAGES-1];
    end

    // Chip select resets to the deasserted level
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sclk_q     <= '0;
            ss_q       <= '1;
            txd_q      <= '0;
            sclk_dly_q <= 1'b0;
        end else begin
            sclk_q     <= sclk_d;
            ss_q       <= ss_d;
            txd_q      <= txd_d;
            sclk_dly_q <= sclk_dly_d;
        end
    end

    assign sclk_rise = sclk_q[STAGES-1] & ~sclk_dly_q;
    assign sclk_fall = ~sclk_q[STAGES-1] & sclk_dly_q;
    assign ss_s      = ss_q[STAGES-1];
    assign txd0_s    = txd_q[STAGES-1];

endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: QSPI flash target serving READ/FAST/QOR
// and READ ID from a synchronous-read fabric byte memory.
module qspi_flash_responder
    import qspi_rsp_pkg::*;
#(
    parameter int          ADDR_W      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int          DUMMY_CLKS  = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              qspi_sclk,
    input  logic              qspi_ss,
    input  logic [3:0]        qspi_txd,
    output logic [3:0]        rsp_dout,
    output logic [3:0]        rsp_oe,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              busy,
    output logic              cmd_err
);

    logic sclk_rise, sclk_fall, ss_s, txd0_s;
    logic unused_txd;

    assign unused_txd = ^qspi_txd[3:1];

    qspi_rsp_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rstn      (rstn),
        .sclk      (qspi_sclk),
        .ss        (qspi_ss),
        .txd0      (qspi_txd[0]),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_s      (ss_s),
        .txd0_s    (txd0_s)
    );

    state_e              state_q, state_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [DUMMY_CW-1:0] dummy_cnt_q, dummy_cnt_d;
    logic [22:0]         sh_in_q, sh_in_d;
    logic                fast_q, fast_d;
    logic                quad_q, quad_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          pos_q, pos_d;
    logic [7:0]          sh_out_q, sh_out_d;
    logic [23:0]         id_sh_q, id_sh_d;
    logic [7:0]          pf_q, pf_d;
    logic                pf_vld_q, pf_vld_d;
    logic                rd_vld_q, rd_vld_d;
    logic [3:0]          dout_q, dout_d;
    logic [3:0]          oe_q, oe_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                busy_q, busy_d;
    logic                cmd_err_q, cmd_err_d;

    logic [7:0]          cmd_shift;
    logic [23:0]         addr_shift;
    logic [7:0]          cur_byte;
    logic [3:0]          data_oe;
    logic [ADDR_W-1:0]   addr_inc;

    // Sequencer: shift in on sclk rise, drive out on sclk fall
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        dummy_cnt_d = dummy_cnt_q;
        sh_in_d     = sh_in_q;
        fast_d      = fast_q;
        quad_d      = quad_q;
        addr_d      = addr_q;
        pos_d       = pos_q;
        sh_out_d    = sh_out_q;
        id_sh_d     = id_sh_q;
        pf_d        = pf_q;
        pf_vld_d    = pf_vld_q;
        rd_vld_d    = mem_rd_en_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        busy_d      = ~ss_s;
        cmd_err_d   = 1'b0;

        cmd_shift  = {sh_in_q[6:0], txd0_s};
        addr_shift = {sh_in_q, txd0_s};
        addr_inc   = addr_q + ADDR_W'(1);
        data_oe    = quad_q ? 4'b1111 : 4'b0010;
        if (pos_q == 3'd0)
            cur_byte = pf_vld_q ? pf_q : 8'hFF;
        else
            cur_byte = sh_out_q;

        if (ss_s) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            dummy_cnt_d = '0;
            sh_in_d     = '0;
            fast_d      = 1'b0;
            quad_d      = 1'b0;
            pos_d       = '0;
            sh_out_d    = '0;
            id_sh_d     = '0;
            pf_vld_d    = 1'b0;
            rd_vld_d    = 1'b0;
            dout_d      = '0;
            oe_d        = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                end
                ST_CMD: if (sclk_rise) begin
                    sh_in_d = addr_shift[22:0];
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        case (cmd_shift)
                            OP_READ: begin
                                state_d = ST_ADDR;
                            end
                            OP_FAST: begin
                                state_d = ST_ADDR;
                                fast_d  = 1'b1;
                            end
                            OP_QOR: begin
                                state_d = ST_ADDR;
                                fast_d  = 1'b1;
                                quad_d  = 1'b1;
                            end
                            OP_RDID: begin
                                state_d = ST_IDOUT;
                                id_sh_d = JEDEC_ID;
                                oe_d    = 4'b0010;
                            end
                            default: begin
                                state_d   = ST_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        endcase
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                ST_ADDR: if (sclk_rise) begin
                    sh_in_d = addr_shift[22:0];
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d   = '0;
                        addr_d      = addr_shift[ADDR_W-1:0];
                        mem_addr_d  = addr_shift[ADDR_W-1:0];
                        mem_rd_en_d = 1'b1;
                        pos_d       = '0;
                        dummy_cnt_d = '0;
                        if (fast_q) begin
                            state_d = ST_DUMMY;
                        end else begin
                            state_d = ST_DATA;
                            oe_d    = data_oe;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                ST_DUMMY: if (sclk_rise) begin
                    if (dummy_cnt_q == DUMMY_CW'(DUMMY_CLKS - 1)) begin
                        state_d = ST_DATA;
                        oe_d    = data_oe;
                    end else begin
                        dummy_cnt_d = dummy_cnt_q + DUMMY_CW'(1);
                    end
                end
                ST_DATA: if (sclk_fall) begin
                    // Loading a new byte frees the prefetch slot
                    if (pos_q == 3'd0) begin
                        pf_vld_d    = 1'b0;
                        addr_d      = addr_inc;
                        mem_addr_d  = addr_inc;
                        mem_rd_en_d = 1'b1;
                    end
                    if (quad_q) begin
                        dout_d   = cur_byte[7:4];
                        sh_out_d = {cur_byte[3:0], 4'b0000};
                        pos_d    = (pos_q == 3'd0) ? 3'd1 : 3'd0;
                    end else begin
                        dout_d   = {2'b00, cur_byte[7], 1'b0};
                        sh_out_d = {cur_byte[6:0], 1'b0};
                        pos_d    = pos_q + 3'd1;
                    end
                end
                ST_IDOUT: if (sclk_fall) begin
                    // Zeros shift in behind the ID bytes
                    dout_d  = {2'b00, id_sh_q[23], 1'b0};
                    id_sh_d = {id_sh_q[22:0], 1'b0};
                end
                ST_IGNORE: begin
                    oe_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (rd_vld_q) begin
                pf_d     = mem_rd_data;
                pf_vld_d = 1'b1;
            end
        end
    end

    // All sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            dummy_cnt_q <= '0;
            sh_in_q     <= '0;
            fast_q      <= 1'b0;
            quad_q      <= 1'b0;
            addr_q      <= '0;
            pos_q       <= '0;
            sh_out_q    <= '0;
            id_sh_q     <= '0;
            pf_q        <= '0;
            pf_vld_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            dout_q      <= '0;
            oe_q        <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            dummy_cnt_q <= dummy_cnt_d;
            sh_in_q     <= sh_in_d;
            fast_q      <= fast_d;
            quad_q      <= quad_d;
            addr_q      <= addr_d;
            pos_q       <= pos_d;
            sh_out_q    <= sh_out_d;
            id_sh_q     <= id_sh_d;
            pf_q        <= pf_d;
            pf_vld_q    <= pf_vld_d;
            rd_vld_q    <= rd_vld_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign rsp_dout  = dout_q;
    assign rsp_oe    = oe_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: directed frames from a table plus
// hand-written abort and reset sequences, sclk = clk/8.
module tb_qspi_flash_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        qspi_sclk;
    logic        qspi_ss;
    logic [3:0]  qspi_txd;
    logic [3:0]  rsp_dout;
    logic [3:0]  rsp_oe;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        busy;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;
    int cmd_err_cnt = 0;

    logic [7:0]  mem [logic [23:0]];
    logic [23:0] rdq [$];

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [23:0] addr;
        int          nclk;
        bit          quad;
        logic [3:0]  oe;
        logic [31:0] exp_data;
        int          exp_nrd;
        logic [23:0] exp_a0;
        logic [23:0] exp_a1;
        int          exp_err;
    } vec_t;

    vec_t vt [6];

    always #5 clk = ~clk;

    qspi_flash_responder dut (
        .clk         (clk),
        .rstn        (rstn),
        .qspi_sclk   (qspi_sclk),
        .qspi_ss     (qspi_ss),
        .qspi_txd    (qspi_txd),
        .rsp_dout    (rsp_dout),
        .rsp_oe      (rsp_oe),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .cmd_err     (cmd_err)
    );

    function automatic logic [7:0] rdmem(input logic [23:0] a);
        if (mem.exists(a))
            return mem[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= rdmem(mem_addr);
            rdq.push_back(mem_addr);
        end
        if (cmd_err)
            cmd_err_cnt <= cmd_err_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One sclk period; d/o are sampled just before the rise
    task automatic sclk_bit(input logic mosi, output logic [3:0] d,
                            output logic [3:0] o);
        qspi_txd = {3'b000, mosi};
        repeat (4) @(negedge clk);
        d = rsp_dout;
        o = rsp_oe;
        qspi_sclk = 1'b1;
        repeat (4) @(negedge clk);
        qspi_sclk = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [23:0] addr,
                             input int nclk, input bit quad,
                             input logic [3:0] exp_oe,
                             output logic [31:0] data,
                             output logic [3:0] oe_dum,
                             output int oe_bad, output logic bsy);
        logic [3:0] d, o;
        data   = '0;
        oe_dum = '0;
        oe_bad = 0;
        qspi_ss = 1'b0;
        repeat (4) @(negedge clk);
        bsy = busy;
        for (int i = 7; i >= 0; i--)
            sclk_bit(op[i], d, o);
        if (op == 8'h03 || op == 8'h0B || op == 8'h6B) begin
            for (int i = 23; i >= 0; i--)
                sclk_bit(addr[i], d, o);
            if (op != 8'h03) begin
                for (int i = 0; i < 8; i++) begin
                    sclk_bit(1'b0, d, o);
                    oe_dum |= o;
                end
            end
        end
        for (int i = 0; i < nclk; i++) begin
            sclk_bit(1'b0, d, o);
            if (o !== exp_oe)
                oe_bad++;
            data = quad ? {data[27:0], d} : {data[30:0], d[1]};
        end
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        qspi_ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [31:0] data;
        logic [3:0]  oe_dum;
        int          oe_bad;
        logic        bsy;
        int          base;
        int          e0;
        int          lat;

        vt[0] = '{"rdid", 8'h9F, 24'h0, 24, 1'b0, 4'b0010,
                  32'h00EF4018, 0, 24'h0, 24'h0, 0};
        vt[1] = '{"read", 8'h03, 24'h000010, 32, 1'b0, 4'b0010,
                  32'hA53CFF00, 6, 24'h000010, 24'h000011, 0};
        vt[2] = '{"qor", 8'h6B, 24'h000100, 4, 1'b1, 4'b1111,
                  32'h00001234, 4, 24'h000100, 24'h000101, 0};
        vt[3] = '{"fast_wrap", 8'h0B, 24'hFFFFFF, 16, 1'b0, 4'b0010,
                  32'h00005AC3, 4, 24'hFFFFFF, 24'h000000, 0};
        vt[4] = '{"badop", 8'h05, 24'h0, 16, 1'b0, 4'b0000,
                  32'h0, 0, 24'h0, 24'h0, 1};
        vt[5] = '{"rdid2", 8'h9F, 24'h0, 24, 1'b0, 4'b0010,
                  32'h00EF4018, 0, 24'h0, 24'h0, 0};

        mem[24'h000010] = 8'hA5;
        mem[24'h000011] = 8'h3C;
        mem[24'h000012] = 8'hFF;
        mem[24'h000013] = 8'h00;
        mem[24'h000100] = 8'h12;
        mem[24'h000101] = 8'h34;
        mem[24'hFFFFFF] = 8'h5A;
        mem[24'h000000] = 8'hC3;

        rstn      = 1'b0;
        qspi_sclk = 1'b0;
        qspi_ss   = 1'b1;
        qspi_txd  = 4'h0;
        repeat (4) @(negedge clk);
        chk("reset_outs",
            {rsp_oe, rsp_dout, busy, cmd_err, mem_rd_en, mem_addr},
            32'h0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_outs",
            {rsp_oe, rsp_dout, busy, cmd_err, mem_rd_en, mem_addr},
            32'h0);

        for (int v = 0; v < 6; v++) begin
            base = rdq.size();
            e0   = cmd_err_cnt;
            run_frame(vt[v].op, vt[v].addr, vt[v].nclk, vt[v].quad,
                      vt[v].oe, data, oe_dum, oe_bad, bsy);
            end_frame();
            chk({vt[v].name, "_data"}, data, vt[v].exp_data);
            chk({vt[v].name, "_oe_bad"}, oe_bad, 0);
            chk({vt[v].name, "_busy"}, {31'h0, bsy}, 32'h1);
            chk({vt[v].name, "_cmd_err"}, cmd_err_cnt - e0, vt[v].exp_err);
            chk({vt[v].name, "_nrd"}, rdq.size() - base, vt[v].exp_nrd);
            chk({vt[v].name, "_end"}, {busy, rsp_oe}, 5'h0);
            if (vt[v].op == 8'h0B || vt[v].op == 8'h6B)
                chk({vt[v].name, "_oe_dummy"}, oe_dum, 4'h0);
            if (vt[v].exp_nrd > 1 && rdq.size() - base > 1) begin
                chk({vt[v].name, "_a0"}, rdq[base], vt[v].exp_a0);
                chk({vt[v].name, "_a1"}, rdq[base + 1], vt[v].exp_a1);
            end
            if (v == 1 && rdq.size() - base > 4) begin
                for (int k = 2; k < 5; k++)
                    chk("read_addr_seq", rdq[base + k], 24'h000010 + k);
            end
        end

        // ss raised after five data bits of a READ
        run_frame(8'h03, 24'h000010, 5, 1'b0, 4'b0010,
                  data, oe_dum, oe_bad, bsy);
        chk("abort_bits", data, 32'h14);
        qspi_ss = 1'b1;
        lat = 0;
        while (rsp_oe !== 4'h0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("abort_oe", rsp_oe, 4'h0);
        if (lat > 3)
            chk("abort_latency", lat, 3);
        repeat (6) @(negedge clk);
        chk("abort_idle", {busy, rsp_dout}, 5'h0);
        run_frame(8'h03, 24'h000012, 16, 1'b0, 4'b0010,
                  data, oe_dum, oe_bad, bsy);
        end_frame();
        chk("after_abort", data, 32'hFF00);
        chk("after_abort_oe", oe_bad, 0);

        // reset asserted in the middle of a QOR data phase
        run_frame(8'h6B, 24'h000100, 2, 1'b1, 4'b1111,
                  data, oe_dum, oe_bad, bsy);
        chk("pre_reset", data, 32'h12);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_reset_outs",
            {rsp_oe, rsp_dout, busy, cmd_err, mem_rd_en, mem_addr},
            32'h0);
        qspi_ss = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        run_frame(8'h6B, 24'h000100, 4, 1'b1, 4'b1111,
                  data, oe_dum, oe_bad, bsy);
        end_frame();
        chk("after_reset", data, 32'h1234);
        chk("after_reset_oe", oe_bad, 0);
        chk("after_reset_dummy", oe_dum, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
